// File: rtl/sym_ex_trace_monitor_pkg.sv
// Shared types and helpers for the symbolic-execution trace monitor.
package sym_ex_trace_monitor_pkg;

    // Monitor FSM states; PASS/FAIL/ERR are terminal and sticky until reset.
    typedef enum logic [2:0] {
        StIdle,
        StTrack,
        StPass,
        StFail,
        StErr
    } state_e;

    // Encoded location index L0..L7.
    typedef logic [2:0] loc_idx_t;

    localparam int unsigned LocW = 8;

    // True when exactly one bit of v is set.
    function automatic logic onehot8(input logic [LocW-1:0] v);
        return (v != 8'h00) && ((v & (v - 8'h01)) == 8'h00);
    endfunction

    // Index of the set bit; only meaningful for one-hot inputs.
    function automatic loc_idx_t encode8(input logic [LocW-1:0] v);
        loc_idx_t idx;
        idx = '0;
        for (int i = 0; i < LocW; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sym_ex_trace_monitor_fifo.sv
// Trace FIFO: head-visible read port, push-while-full accepted only alongside a pop,
// sticky overflow flag for dropped pushes.
module sym_ex_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic [DW-1:0] push_data_i,
    input  logic          rd_en_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_empty_o,
    output logic          ovf_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;

    logic full;
    logic empty;
    logic pop_ok;
    logic push_ok;

    // Accept/pop decisions; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        full       = (count_q == CW'(DEPTH));
        empty      = (count_q == '0);
        pop_ok     = rd_en_i && !empty;
        push_ok    = push_i && (!full || pop_ok);
        rd_empty_o = empty;
        rd_data_o  = empty ? '0 : mem_q[rd_ptr_q];
        ovf_o      = ovf_q;
    end

    // Storage, pointers (wrap naturally for power-of-two DEPTH), count and overflow.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok && !pop_ok) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop_ok) begin
                count_q <= count_q - CW'(1);
            end
            if (push_i && !push_ok) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sym_ex_trace_monitor.sv
// Trace monitor: follows a one-hot location stream from L0, logs each location change
// into a trace FIFO and terminates on L6 (pass), L7 (fail), a bad vector or a timeout.
module sym_ex_trace_monitor
    import sym_ex_trace_monitor_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   loc,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic         rd_en,
    output logic [2:0]   rd_data,
    output logic         rd_empty,
    output logic         ovf,
    output logic         done,
    output logic         pass,
    output logic         fail,
    output logic         err,
    output logic [W-1:0] fail_xy,
    output logic [3:0]   cyc,
    output logic         prop
);

    state_e       state_q, state_d;
    logic [7:0]   prev_loc_q, prev_loc_d;
    logic [3:0]   cyc_q, cyc_d;
    logic [W-1:0] fail_xy_q, fail_xy_d;
    logic         pass_q, fail_q, err_q, done_q, prop_q;
    logic         push;
    loc_idx_t     push_idx;
    logic [3:0]   cyc_inc;

    // z is part of the upstream register set but plays no role in the checked property.
    logic unused_z;
    assign unused_z = ^z;

    // Next-state, trace push and capture logic.
    always_comb begin
        state_d    = state_q;
        prev_loc_d = prev_loc_q;
        cyc_d      = cyc_q;
        fail_xy_d  = fail_xy_q;
        push       = 1'b0;
        push_idx   = encode8(loc);
        cyc_inc    = (cyc_q == 4'hF) ? 4'hF : cyc_q + 4'h1;

        unique case (state_q)
            StIdle: begin
                if (loc == 8'h01) begin
                    state_d    = StTrack;
                    push       = 1'b1;
                    cyc_d      = 4'h0;
                    prev_loc_d = loc;
                end
            end
            StTrack: begin
                cyc_d = cyc_inc;
                // A malformed vector outranks every other tracking rule.
                if (!onehot8(loc)) begin
                    state_d = StErr;
                end else begin
                    if (loc != prev_loc_q) begin
                        push       = 1'b1;
                        prev_loc_d = loc;
                    end
                    if (loc[7]) begin
                        state_d   = StFail;
                        fail_xy_d = x + y;
                    end else if (loc[6]) begin
                        state_d = StPass;
                    end else if (32'(cyc_inc) >= TIMEOUT) begin
                        state_d = StErr;
                    end
                end
            end
            default: ;
        endcase
    end

    // State, captured data and registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            prev_loc_q <= 8'h00;
            cyc_q      <= 4'h0;
            fail_xy_q  <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            prop_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_loc_q <= prev_loc_d;
            cyc_q      <= cyc_d;
            fail_xy_q  <= fail_xy_d;
            pass_q     <= (state_d == StPass);
            fail_q     <= (state_d == StFail);
            err_q      <= (state_d == StErr);
            done_q     <= (state_d == StPass) || (state_d == StFail) || (state_d == StErr);
            prop_q     <= (state_d != StFail);
        end
    end

    sym_ex_trace_fifo #(
        .DEPTH(DEPTH),
        .DW   (3)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_i     (push),
        .push_data_i(push_idx),
        .rd_en_i    (rd_en),
        .rd_data_o  (rd_data),
        .rd_empty_o (rd_empty),
        .ovf_o      (ovf)
    );

    // Drive registered status onto the ports.
    always_comb begin
        pass    = pass_q;
        fail    = fail_q;
        err     = err_q;
        done    = done_q;
        prop    = prop_q;
        cyc     = cyc_q;
        fail_xy = fail_xy_q;
    end

endmodule
